// File: rtl/bg_parallax_starfield_if.sv
// Pixel-timing inputs and 2-bit-per-channel RGB outputs of the parallax starfield background.
interface bg_parallax_starfield_if;
    logic        bg_en;
    logic        video_active;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        vsync;
    logic        scroll_pause;
    logic [1:0]  R;
    logic [1:0]  G;
    logic [1:0]  B;

    modport master (
        output bg_en, video_active, pix_x, pix_y, vsync, scroll_pause,
        input  R, G, B
    );

    modport slave (
        input  bg_en, video_active, pix_x, pix_y, vsync, scroll_pause,
        output R, G, B
    );
endinterface

// File: rtl/bg_parallax_starfield.sv
// Hashed-cell parallax starfield with per-layer horizontal scroll and a 3-stage pixel pipeline.
// Optional per-star twinkle is enabled by defining BG_PARALLAX_TWINKLE_EN.
module bg_parallax_starfield #(
    parameter int          H_RES      = 1024,
    parameter int          V_RES      = 768,
    parameter int          NUM_LAYERS = 3,
    parameter int          CELL_LOG2  = 4,
    parameter logic [7:0]  DENSITY    = 8'd40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bg_parallax_starfield_if.slave   bus
);

    localparam logic [11:0] HRES12 = 12'(H_RES);

    function automatic logic [15:0] cell_hash(input logic [15:0] key);
        logic [15:0] a;
        logic [15:0] b;
        a = key ^ (key << 7);
        b = a ^ (a >> 9);
        return b ^ (b << 8);
    endfunction

    logic                 vsync_q;
    logic                 frame_tick;
    logic [15:0]          frame_cnt_q;
    logic [10:0]          scroll_q  [NUM_LAYERS];
    logic [10:0]          scroll_d  [NUM_LAYERS];
    logic [11:0]          step_sum  [NUM_LAYERS];

    logic [11:0]          wx_sum    [NUM_LAYERS];
    logic [10:0]          wx        [NUM_LAYERS];
    logic [6:0]           cx_q      [NUM_LAYERS];
    logic [CELL_LOG2-1:0] ox_q      [NUM_LAYERS];
    logic [6:0]           cy_q;
    logic [CELL_LOG2-1:0] oy_q;
    logic                 act1_q;
    logic                 en1_q;

    logic [15:0]          hh        [NUM_LAYERS];
    logic [16:0]          hh_ext    [NUM_LAYERS];
    logic                 twk       [NUM_LAYERS];
    logic                 hit_d     [NUM_LAYERS];
    logic                 hit_q     [NUM_LAYERS];
    logic [1:0]           tint_q    [NUM_LAYERS];
    logic                 act2_q;
    logic                 en2_q;

    logic [1:0]           win_lvl;
    logic [1:0]           win_tint;
    logic                 win_any;
    logic [5:0]           rgb_d;
    logic [5:0]           rgb_q;
    logic                 unused_bits;

    assign frame_tick = bus.vsync & ~vsync_q;

    // Per-frame scroll advance and per-pixel wrapped world column; both need only one subtract.
    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            step_sum[k] = {1'b0, scroll_q[k]} + 12'(k + 1);
            scroll_d[k] = scroll_q[k];
            if (frame_tick && bus.bg_en && !bus.scroll_pause) begin
                scroll_d[k] = (step_sum[k] >= HRES12) ? 11'(step_sum[k] - HRES12) : step_sum[k][10:0];
            end
            wx_sum[k] = {1'b0, bus.pix_x} + {1'b0, scroll_q[k]};
            wx[k]     = (wx_sum[k] >= HRES12) ? 11'(wx_sum[k] - HRES12) : wx_sum[k][10:0];
        end
    end

    // Zero-extended hash so offset fields past bit 15 (CELL_LOG2=5) read as 0.
    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            hh[k]     = cell_hash({2'(k), cx_q[k], cy_q});
            hh_ext[k] = {1'b0, hh[k]};
`ifdef BG_PARALLAX_TWINKLE_EN
            twk[k]    = ((hh[k][2:0] ^ frame_cnt_q[5:3]) == 3'd0);
`else
            twk[k]    = 1'b0;
`endif
            hit_d[k]  = (hh[k][7:0] < DENSITY)
                     && (ox_q[k] == hh_ext[k][8 +: CELL_LOG2])
                     && (oy_q == hh_ext[k][12 +: CELL_LOG2])
                     && !twk[k];
        end
    end

    // The nearest (highest-index) hitting layer sets brightness and tint.
    always_comb begin
        win_lvl  = 2'b00;
        win_tint = 2'b00;
        win_any  = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (hit_q[k]) begin
                win_any  = 1'b1;
                win_tint = tint_q[k];
                win_lvl  = (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b11);
            end
        end
        case (win_tint)
            2'd1:    rgb_d = {win_lvl >> 1, win_lvl >> 1, win_lvl};
            2'd2:    rgb_d = {win_lvl, win_lvl, 2'b00};
            default: rgb_d = {win_lvl, win_lvl, win_lvl};
        endcase
        if (!win_any || !act2_q || !en2_q) begin
            rgb_d = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                scroll_q[k] <= '0;
                cx_q[k]     <= '0;
                ox_q[k]     <= '0;
                hit_q[k]    <= 1'b0;
                tint_q[k]   <= '0;
            end
            cy_q   <= '0;
            oy_q   <= '0;
            act1_q <= 1'b0;
            en1_q  <= 1'b0;
            act2_q <= 1'b0;
            en2_q  <= 1'b0;
            rgb_q  <= '0;
        end else begin
            vsync_q <= bus.vsync;
            if (frame_tick && bus.bg_en) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            for (int k = 0; k < NUM_LAYERS; k++) begin
                scroll_q[k] <= scroll_d[k];
                cx_q[k]     <= 7'(wx[k] >> CELL_LOG2);
                ox_q[k]     <= wx[k][CELL_LOG2-1:0];
                hit_q[k]    <= hit_d[k];
                tint_q[k]   <= hh[k][9:8];
            end
            cy_q   <= 7'(bus.pix_y >> CELL_LOG2);
            oy_q   <= bus.pix_y[CELL_LOG2-1:0];
            act1_q <= bus.video_active;
            en1_q  <= bus.bg_en;
            act2_q <= act1_q;
            en2_q  <= en1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign bus.R = rgb_q[5:4];
    assign bus.G = rgb_q[3:2];
    assign bus.B = rgb_q[1:0];

    // Bits that only some parameter/macro combinations consume.
    always_comb begin
        unused_bits = ^frame_cnt_q ^ ^bus.pix_y ^ ^(11'(V_RES));
        for (int k = 0; k < NUM_LAYERS; k++) begin
            unused_bits = unused_bits ^ ^wx[k] ^ ^hh_ext[k];
        end
    end

endmodule

// File: tb/tb_bg_parallax_starfield.sv
// Scoreboard bench for bg_parallax_starfield (H_RES=1000); honours BG_PARALLAX_TWINKLE_EN.
module tb_bg_parallax_starfield;

    localparam int H = 1000;
    localparam int NL = 3;

    typedef struct {
        logic [5:0] rgb;
        int         x;
        int         y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bg_parallax_starfield_if bus ();

    bg_parallax_starfield #(
        .H_RES(H), .V_RES(768), .NUM_LAYERS(NL), .CELL_LOG2(4), .DENSITY(8'd40)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          scrollM [NL];
    logic [15:0] fcntM = '0;
    exp_t        expQ [$];
    logic        drvValid = 1'b0;
    logic [2:0]  vldPipe = '0;
    exp_t        popped;
    logic [5:0]  obsV;

    function automatic logic [15:0] hashOf(input int k, input int cx, input int cy);
        logic [15:0] key, a, b;
        key = {2'(k), 7'(cx), 7'(cy)};
        a = key ^ (key << 7);
        b = a ^ (a >> 9);
        return b ^ (b << 8);
    endfunction

    function automatic void layerHit(input int k, input int x, input int y,
                                     output logic hit, output logic [1:0] tint);
        int wx;
        logic [15:0] h;
        wx = x + scrollM[k];
        if (wx >= H) wx -= H;
        h = hashOf(k, (wx >> 4) & 127, (y >> 4) & 127);
        hit = (h[7:0] < 8'd40) && (4'(wx & 15) == h[11:8]) && (4'(y & 15) == h[15:12]);
`ifdef BG_PARALLAX_TWINKLE_EN
        if ((h[2:0] ^ fcntM[5:3]) == 3'd0) hit = 1'b0;
`endif
        tint = h[9:8];
    endfunction

    function automatic logic [5:0] expRgb(input int x, input int y, input logic act, input logic en);
        logic hit;
        logic [1:0] t, lvl, tint, half;
        bit any;
        any = 0; lvl = 2'd0; tint = 2'd0;
        for (int k = 0; k < NL; k++) begin
            layerHit(k, x, y, hit, t);
            if (hit) begin
                any = 1;
                tint = t;
                lvl = (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b11);
            end
        end
        if (!any || !act || !en) return 6'd0;
        half = lvl >> 1;
        case (tint)
            2'd1:    return {half, half, lvl};
            2'd2:    return {lvl, lvl, 2'b00};
            default: return {lvl, lvl, lvl};
        endcase
    endfunction

    // Locate a layer-k star on screen at the current model offsets; lowBits<0 accepts any h[2:0].
    function automatic void findStar(input int k, input int lowBits, output int fx, output int fy, output bit ok);
        logic [15:0] h;
        int wx;
        ok = 0; fx = 0; fy = 0;
        for (int cy = 0; cy < 48 && !ok; cy++) begin
            for (int cx = 0; cx < 63 && !ok; cx++) begin
                h = hashOf(k, cx, cy);
                if (h[7:0] < 8'd40 && (lowBits < 0 || int'(h[2:0]) == lowBits)) begin
                    wx = cx * 16 + int'(h[11:8]);
                    if (wx < H) begin
                        fy = cy * 16 + int'(h[15:12]);
                        fx = wx - scrollM[k];
                        if (fx < 0) fx += H;
                        ok = 1;
                    end
                end
            end
        end
    endfunction

    function automatic void findOverlap(output int fx, output int fy, output bit ok);
        logic [15:0] h;
        logic hit;
        logic [1:0] t;
        int wx;
        ok = 0; fx = 0; fy = 0;
        for (int cy = 0; cy < 48 && !ok; cy++) begin
            for (int cx = 0; cx < 63 && !ok; cx++) begin
                h = hashOf(2, cx, cy);
                wx = cx * 16 + int'(h[11:8]);
                if (h[7:0] < 8'd40 && wx < H) begin
                    fy = cy * 16 + int'(h[15:12]);
                    fx = wx - scrollM[2];
                    if (fx < 0) fx += H;
                    for (int kk = 0; kk < 2; kk++) begin
                        layerHit(kk, fx, fy, hit, t);
                        if (hit) ok = 1;
                    end
                end
            end
        end
    endfunction

    task automatic applyStimulus(input int x, input int y, input logic act, input logic en);
        exp_t e;
        @(negedge clk);
        bus.pix_x = 11'(x);
        bus.pix_y = 11'(y);
        bus.video_active = act;
        bus.bg_en = en;
        drvValid = 1'b1;
        e.rgb = expRgb(x, y, act, en);
        e.x = x;
        e.y = y;
        expQ.push_back(e);
    endtask

    task automatic streamAround(input int x, input int y, input logic act, input logic en);
        for (int dx = -2; dx <= 2; dx++) begin
            if (x + dx >= 0 && x + dx < H) applyStimulus(x + dx, y, act, en);
        end
    endtask

    task automatic flush();
        @(negedge clk);
        drvValid = 1'b0;
        bus.video_active = 1'b0;
        bus.bg_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic modelTick();
        if (bus.bg_en) begin
            fcntM = fcntM + 16'd1;
            if (!bus.scroll_pause) begin
                for (int k = 0; k < NL; k++) begin
                    scrollM[k] += k + 1;
                    if (scrollM[k] >= H) scrollM[k] -= H;
                end
            end
        end
    endtask

    task automatic doTick();
        @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        modelTick();
    endtask

    task automatic checkOutput(input string tag);
        for (int k = 0; k < NL; k++) begin
            total++;
            assert (dut.scroll_q[k] === 11'(scrollM[k])) else begin
                bad++;
                $error("FAIL %s_scroll%0d got=%0d want=%0d", tag, k, dut.scroll_q[k], scrollM[k]);
            end
        end
        total++;
        assert (dut.frame_cnt_q === fcntM) else begin
            bad++;
            $error("FAIL %s_frame_cnt got=%0d want=%0d", tag, dut.frame_cnt_q, fcntM);
        end
    endtask

    task automatic checkLit(input string tag, input int got, input int want);
        total++;
        assert (got == want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    always @(posedge clk) vldPipe <= {vldPipe[1:0], drvValid};

    // Output side of the scoreboard: each driven pixel surfaces three edges later.
    always @(negedge clk) begin
        if (vldPipe[2]) begin
            obsV = {bus.R, bus.G, bus.B};
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $error("FAIL scoreboard_empty got=%b want=queued_entry", obsV);
            end else begin
                popped = expQ.pop_front();
                assert (obsV === popped.rgb) else begin
                    bad++;
                    $error("FAIL pixel_rgb x=%0d y=%0d got=%b want=%b", popped.x, popped.y, obsV, popped.rgb);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sx, sy;
        bit ok;
        for (int k = 0; k < NL; k++) scrollM[k] = 0;
        bus.bg_en = 1'b1;
        bus.video_active = 1'b1;
        bus.pix_x = 11'd0;
        bus.pix_y = 11'd0;
        bus.vsync = 1'b0;
        bus.scroll_pause = 1'b0;

        // Reset held with active pixels
        repeat (2) begin
            @(negedge clk);
            total++;
            assert ({bus.R, bus.G, bus.B} === 6'd0) else begin
                bad++;
                $error("FAIL reset_rgb got=%b want=%b", {bus.R, bus.G, bus.B}, 6'd0);
            end
        end
        rst_n = 1'b1;
        checkOutput("reset");

        // Layer-2 star at frame 0 plus its neighbours
        findStar(2, 1, sx, sy, ok);
        if (ok) streamAround(sx, sy, 1'b1, 1'b1);
        else $display("[TB] note: no layer-2 star located");
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, H - 1), $urandom_range(0, 767), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
        end
        flush();

        // Preload to the wrap boundary
        repeat (333) doTick();
        checkOutput("preload");
        checkLit("preload_scroll2", int'(dut.scroll_q[2]), 999);
        doTick();
        checkOutput("wrap");
        checkLit("wrap_scroll0", int'(dut.scroll_q[0]), 334);
        checkLit("wrap_scroll1", int'(dut.scroll_q[1]), 668);
        checkLit("wrap_scroll2", int'(dut.scroll_q[2]), 2);

        // Long vsync pulse counts once
        @(negedge clk);
        bus.vsync = 1'b1;
        repeat (500) @(negedge clk);
        bus.vsync = 1'b0;
        modelTick();
        @(negedge clk);
        checkOutput("long_vsync");
        checkLit("long_vsync_fcnt", int'(dut.frame_cnt_q), 335);

        // Paused scrolling still counts frames
        bus.scroll_pause = 1'b1;
        repeat (10) doTick();
        bus.scroll_pause = 1'b0;
        checkOutput("pause");
        checkLit("pause_fcnt", int'(dut.frame_cnt_q), 345);

        // Disabled block freezes everything
        @(negedge clk);
        bus.bg_en = 1'b0;
        repeat (3) doTick();
        checkOutput("disabled");
        bus.bg_en = 1'b1;

        // Masking at a known star pixel
        findStar(2, -1, sx, sy, ok);
        if (ok) begin
            applyStimulus(sx, sy, 1'b1, 1'b1);
            applyStimulus(sx, sy, 1'b0, 1'b1);
            applyStimulus(sx, sy, 1'b1, 1'b0);
            applyStimulus(sx, sy, 1'b1, 1'b1);
        end
        flush();

        // Step frames until two layers share a pixel
        ok = 0;
        for (int i = 0; i < 150 && !ok; i++) begin
            findOverlap(sx, sy, ok);
            if (!ok) doTick();
        end
        if (ok) streamAround(sx, sy, 1'b1, 1'b1);
        else $display("[TB] note: no overlapping stars within frame budget");
        flush();

        // Twinkle phase: star with h[2:0]=5 at frame_cnt[5:3]=4 then 5
        bus.scroll_pause = 1'b1;
        for (int i = 0; i < 64 && fcntM[5:3] != 3'd4; i++) doTick();
        findStar(2, 5, sx, sy, ok);
        if (ok) streamAround(sx, sy, 1'b1, 1'b1);
        flush();
        repeat (8) doTick();
        if (ok) streamAround(sx, sy, 1'b1, 1'b1);
        flush();
        bus.scroll_pause = 1'b0;
        checkOutput("twinkle");

        repeat (4) @(negedge clk);
        total++;
        assert (expQ.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain got=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
